// File: rtl/mem_sched_pkg.sv
// Shared types and defaults for the memory-port scheduler and its rotating picker.
package mem_sched_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned LEN_W_DEF = 4;

    typedef enum logic [0:0] {StIdle, StBusy} sched_state_e;

    function automatic int unsigned idx_w(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// Requester/memory-port handshake bundle seen by the scheduler.
interface mem_port_sched_if
    import mem_sched_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned IDX_W = idx_w(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] burst_len;
    logic                  beat_ack;
    logic [NREQ-1:0]       gnt;
    logic [IDX_W-1:0]      owner;
    logic                  busy;
    logic [NREQ-1:0]       done;

    modport master (
        output req, burst_len, beat_ack,
        input  gnt, owner, busy, done
    );

    modport slave (
        input  req, burst_len, beat_ack,
        output gnt, owner, busy, done
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first request at or above last_ptr + 1, wrapping.
module rr_pick
    import mem_sched_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((32'(last_ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any      = 1'b1;
                pick_idx = cand;
            end
        end
        pick[pick_idx] = any;
    end

endmodule

// File: rtl/mem_port_sched.sv
// Burst-aware round-robin owner of a single memory port; a grant lasts len + 1 acked beats.
module mem_port_sched
    import mem_sched_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input logic              clk,
    input logic              rst,
    mem_port_sched_if.slave  bus
);

    localparam int unsigned IDX_W = idx_w(NREQ);

    sched_state_e     state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_cnt, beat_cnt_d;
    logic [IDX_W-1:0] last_ptr, last_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;

    logic [NREQ-1:0]  pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (bus.req),
        .last_ptr (last_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt;
        last_ptr_d = last_ptr;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d    = StBusy;
                    gnt_d      = pick;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    len_d      = '0;
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (pick[i]) len_d = bus.burst_len[i*LEN_W +: LEN_W];
                    end
                end
            end
            StBusy: begin
                if (bus.beat_ack) begin
                    // Compare before increment so an all-ones length never wraps the counter.
                    if (beat_cnt == len_q) begin
                        state_d    = StIdle;
                        gnt_d      = '0;
                        done_d     = gnt_q;
                        last_ptr_d = owner_q;
                        owner_d    = '0;
                    end else begin
                        beat_cnt_d = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            len_q    <= '0;
            beat_cnt <= '0;
            last_ptr <= IDX_W'(NREQ - 1);
            owner_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            beat_cnt <= beat_cnt_d;
            last_ptr <= last_ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == StBusy);
    assign bus.done  = done_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Randomised and directed bench for mem_port_sched against a burst-level reference model.
module tb_mem_port_sched;
    import mem_sched_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned LEN_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_sched_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

    mem_port_sched #(
        .NREQ  (NREQ),
        .LEN_W (LEN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int gnt_cycles;
    int done_seen;

    // Reference: who owns the port and how many beats remain in the burst.
    bit              m_busy;
    int              m_owner;
    int              m_left;
    int              m_last;
    logic [NREQ-1:0] m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_left  = 0;
            m_last  = NREQ - 1;
            m_done  = '0;
        end else begin
            m_done = '0;
            if (!m_busy) begin
                for (int k = 1; k <= int'(NREQ); k++) begin
                    int i;
                    i = (m_last + k) % NREQ;
                    if (!m_busy && bus.req[i]) begin
                        m_busy  = 1'b1;
                        m_owner = i;
                        m_left  = int'(bus.burst_len[i*LEN_W +: LEN_W]) + 1;
                    end
                end
            end else if (bus.beat_ack) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy     = 1'b0;
                    m_done[m_owner] = 1'b1;
                    m_last     = m_owner;
                end
            end
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] exp_gnt;
        @(posedge clk);
        model_edge();
        #1;
        exp_gnt = m_busy ? (NREQ'(1) << m_owner) : '0;
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        if (m_busy) check("owner", 32'(bus.owner), 32'(m_owner));
        if (bus.gnt != 0) gnt_cycles++;
        if (bus.done != 0) done_seen++;
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ*LEN_W-1:0] lens,
                         input logic ack, input logic rs);
        bus.req       = r;
        bus.burst_len = lens;
        bus.beat_ack  = ack;
        rst           = rs;
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b0, 1'b1);
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] grants[$];
        logic [NREQ-1:0] prev;
        logic [4:0]      stall;

        do_reset();
        step();

        // Single request, length 2.
        gnt_cycles = 0; done_seen = 0;
        drive(4'b0001, 16'h0002, 1'b1, 1'b0);
        step();
        bus.req = '0;
        repeat (5) step();
        check("single_len", 32'(gnt_cycles), 32'd3);
        check("single_done", 32'(done_seen), 32'd1);

        // Rotation with zero-length bursts.
        do_reset();
        drive(4'b1011, 16'h0000, 1'b1, 1'b0);
        prev = '0;
        repeat (8) begin
            step();
            if (bus.gnt != 0 && prev == 0) grants.push_back(bus.gnt);
            prev = bus.gnt;
        end
        check("rot_n", 32'(grants.size()), 32'd4);
        if (grants.size() >= 4) begin
            check("rot0", 32'(grants[0]), 32'h1);
            check("rot1", 32'(grants[1]), 32'h2);
            check("rot2", 32'(grants[2]), 32'h8);
            check("rot3", 32'(grants[3]), 32'h1);
        end

        // Length sampled only at grant.
        do_reset();
        gnt_cycles = 0;
        drive(4'b0010, 16'h0030, 1'b1, 1'b0);
        step();
        drive(4'b0000, 16'h0000, 1'b1, 1'b0);
        repeat (6) step();
        check("len_sample", 32'(gnt_cycles), 32'd4);

        // Stalled port, owner drops req.
        do_reset();
        gnt_cycles = 0;
        drive(4'b0001, 16'h0001, 1'b0, 1'b0);
        step();
        bus.req = '0;
        stall = 5'b10100;
        for (int i = 0; i < 5; i++) begin
            bus.beat_ack = stall[i];
            step();
        end
        bus.beat_ack = 1'b0;
        step();
        check("stall_len", 32'(gnt_cycles), 32'd5);

        // Maximum length.
        do_reset();
        gnt_cycles = 0;
        drive(4'b0001, 16'h000F, 1'b1, 1'b0);
        step();
        bus.req = '0;
        repeat (18) step();
        check("max_len", 32'(gnt_cycles), 32'd16);

        // Reset mid-burst.
        do_reset();
        done_seen = 0;
        drive(4'b0100, 16'h3333, 1'b1, 1'b0);
        step();
        bus.req = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        bus.req = 4'b1111;
        step();
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_nodone", 32'(done_seen), 32'd0);

        // Random traffic.
        repeat (3000) begin
            drive(NREQ'($urandom), (NREQ*LEN_W)'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
